jk_count_monitor: RTL and testbench
===================================

JK_COUNT_MONITOR -- requirements
Module: jk_count_monitor

Interface
REQ-001 Parameter: POS_W, default 8, width of the signed position accumulator.
REQ-002 c  input  1  clock; all state changes on rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of c.
REQ-004 a  input  1  observed count MSB (from 2-bit JK counter q output).
REQ-005 b  input  1  observed count LSB (from 2-bit JK counter q1 output).
REQ-006 clr  input  1  synchronous fault clear / resync request.
REQ-007 e_rec  output  1  recovered count-enable: 1 = count moved this step.
REQ-008 f_rec  output  1  recovered direction: 1 = up, 0 = down.
REQ-009 valid  output  1  e_rec/f_rec/pos are meaningful.
REQ-010 err  output  1  one-cycle pulse on illegal transition.
REQ-011 fault  output  1  sticky fault, high while in FAULT state.
REQ-012 dir_chg  output  1  one-cycle pulse when a move reverses the previous move's direction.
REQ-013 pos  output  POS_W  signed net step count (up minus down), two's complement.
REQ-014 err_cnt  output  4  illegal-transition count (see Configuration).

Function
REQ-015 Decode rule: cur={a,b}, prv=registered previous sample; cur==prv -> hold; cur==prv+1 mod 4 -> up; cur==prv-1 mod 4 -> down; cur==prv+2 mod 4 -> illegal.
REQ-016 FSM states SYNC, TRACK, FAULT; reset state SYNC.
REQ-017 SYNC: load prv<=cur, go TRACK next edge; valid=0, e_rec=0, no pos update.
REQ-018 TRACK: every edge prv<=cur; decode per REQ-015; outputs registered, one cycle latency from sample edge.
REQ-019 TRACK hold: e_rec=0, f_rec retains last value, pos unchanged, valid=1.
REQ-020 TRACK up: e_rec=1, f_rec=1, pos<=pos+1; TRACK down: e_rec=1, f_rec=0, pos<=pos-1; valid=1.
REQ-021 pos wraps modulo 2^POS_W (+127 up -> -128 for POS_W=8); no saturation.
REQ-022 dir_chg=1 for one cycle when a move's direction differs from the most recent prior move since entering TRACK; first move after SYNC never asserts dir_chg.
REQ-023 TRACK illegal: err=1 one cycle, go FAULT; e_rec=0, valid=0, pos holds.
REQ-024 FAULT: fault=1, valid=0, e_rec=0, prv not updated; stays until clr=1.
REQ-025 clr=1 in any state: next state SYNC, fault=0, pos<=0, f_rec<=0; clr overrides a simultaneous illegal transition (no err pulse).
REQ-026 Priority: reset > clr > decode.

Reset
REQ-027 reset=0 at rising edge: state SYNC; e_rec, f_rec, valid, err, fault, dir_chg = 0; pos = 0; prv = 2'b00; err_cnt = 0.
REQ-028 Reset asserted mid-TRACK or mid-FAULT aborts immediately; first post-reset edge behaves per REQ-017.

Configuration
REQ-029 Macro JKMON_ERRCNT_EN defined: err_cnt increments on each err pulse, saturates at 15, cleared only by reset (not by clr).
REQ-030 Macro JKMON_ERRCNT_EN undefined: err_cnt port present, driven constant 0; no counter logic.

Verification
REQ-031 Reset low 2 edges, release, {a,b}=00 steady -> valid=1 from 2nd edge after release, e_rec=0, pos=0.
REQ-032 Drive 00,01,10,11,00 one per edge -> e_rec=1, f_rec=1 each step, pos=4, dir_chg never set.
REQ-033 Drive 00,01,10,01,00 -> f_rec 1,1,0,0; dir_chg single pulse on 10->01; pos ends 0.
REQ-034 In TRACK at 01 drive 11 -> err pulse 1 cycle, fault=1, valid=0; clr=1 one edge -> SYNC then TRACK, pos=0; with JKMON_ERRCNT_EN err_cnt=1, without err_cnt=0.
REQ-035 129 consecutive up steps from pos=0 (POS_W=8) -> pos=-127 (0x81); illegal jump coincident with clr=1 -> no err pulse, state SYNC.
REQ-036 Reset asserted while fault=1 and err_cnt=3 -> all outputs 0 next edge, err_cnt=0.

Source files
------------

// File: rtl/jk_count_monitor_if.sv
// Bundles the observed JK counter bits, clear request and recovered outputs.
// The DUT takes the slave modport and the bench takes the master modport.
interface jk_count_monitor_if #(
    parameter int POS_W = 8
);
    logic                    a;
    logic                    b;
    logic                    clr;
    logic                    e_rec;
    logic                    f_rec;
    logic                    valid;
    logic                    err;
    logic                    fault;
    logic                    dir_chg;
    logic signed [POS_W-1:0] pos;
    logic [3:0]              err_cnt;

    modport master (
        output a, b, clr,
        input  e_rec, f_rec, valid, err, fault, dir_chg, pos, err_cnt
    );

    modport slave (
        input  a, b, clr,
        output e_rec, f_rec, valid, err, fault, dir_chg, pos, err_cnt
    );
endinterface

// File: rtl/jk_count_monitor.sv
// Recovers enable/direction and a signed position from a 2-bit JK counter's outputs.
// Defining JKMON_ERRCNT_EN adds a saturating illegal-transition counter on err_cnt.
module jk_count_monitor #(
    parameter int POS_W = 8
) (
    input  logic                c,
    input  logic                reset,
    jk_count_monitor_if.slave   bus
);
    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       prv_q, prv_d;
    logic [1:0]       cur, delta;
    logic             e_rec_q, e_rec_d;
    logic             f_rec_q, f_rec_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             fault_q, fault_d;
    logic             dir_chg_q, dir_chg_d;
    logic             have_move_q, have_move_d;
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        cur         = {bus.a, bus.b};
        delta       = cur - prv_q;
        state_d     = state_q;
        prv_d       = prv_q;
        e_rec_d     = 1'b0;
        f_rec_d     = f_rec_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        fault_d     = 1'b0;
        dir_chg_d   = 1'b0;
        have_move_d = have_move_q;
        pos_d       = pos_q;

        if (bus.clr) begin
            state_d     = SYNC;
            pos_d       = '0;
            f_rec_d     = 1'b0;
            have_move_d = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    prv_d       = cur;
                    state_d     = TRACK;
                    have_move_d = 1'b0;
                end
                TRACK: begin
                    prv_d   = cur;
                    valid_d = 1'b1;
                    // f_rec_q holds the last move's direction; have_move_q gates the first move
                    case (delta)
                        2'd0: ;
                        2'd1: begin
                            e_rec_d     = 1'b1;
                            f_rec_d     = 1'b1;
                            pos_d       = pos_q + POS_W'(1);
                            dir_chg_d   = have_move_q && !f_rec_q;
                            have_move_d = 1'b1;
                        end
                        2'd3: begin
                            e_rec_d     = 1'b1;
                            f_rec_d     = 1'b0;
                            pos_d       = pos_q - POS_W'(1);
                            dir_chg_d   = have_move_q && f_rec_q;
                            have_move_d = 1'b1;
                        end
                        default: begin
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end
                    endcase
                end
                FAULT:   fault_d = 1'b1;
                default: state_d = SYNC;
            endcase
        end
    end

`ifdef JKMON_ERRCNT_EN
    logic [3:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 4'hF)) err_cnt_d = err_cnt_q + 4'd1;
    end

    always_ff @(posedge c) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    always_ff @(posedge c) begin
        if (!reset) begin
            state_q     <= SYNC;
            prv_q       <= 2'b00;
            e_rec_q     <= 1'b0;
            f_rec_q     <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
            dir_chg_q   <= 1'b0;
            have_move_q <= 1'b0;
            pos_q       <= '0;
        end else begin
            state_q     <= state_d;
            prv_q       <= prv_d;
            e_rec_q     <= e_rec_d;
            f_rec_q     <= f_rec_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
            dir_chg_q   <= dir_chg_d;
            have_move_q <= have_move_d;
            pos_q       <= pos_d;
        end
    end

    assign bus.e_rec   = e_rec_q;
    assign bus.f_rec   = f_rec_q;
    assign bus.valid   = valid_q;
    assign bus.err     = err_q;
    assign bus.fault   = fault_q;
    assign bus.dir_chg = dir_chg_q;
    assign bus.pos     = pos_q;
endmodule

// File: tb/tb_jk_count_monitor.sv
// Scoreboard bench for jk_count_monitor: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry per clock edge.
module tb_jk_count_monitor;
    localparam int POS_W = 8;
`ifdef JKMON_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    typedef struct {
        bit          chk;
        string       name;
        logic [17:0] exp;
    } exp_t;

    logic        c = 1'b0;
    logic        reset;
    logic [17:0] act;
    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    jk_count_monitor_if #(.POS_W(POS_W)) bus();

    jk_count_monitor #(.POS_W(POS_W)) dut (
        .c     (c),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c = ~c;

    assign act = {bus.e_rec, bus.f_rec, bus.valid, bus.err, bus.fault, bus.dir_chg,
                  bus.pos, bus.err_cnt};

    // Packs {e_rec,f_rec,valid,err,fault,dir_chg,pos,err_cnt}; the count only exists with the macro.
    function automatic logic [17:0] pk(input bit e, input bit f, input bit v, input bit er,
                                       input bit ft, input bit dc, input logic [7:0] p,
                                       input logic [3:0] ec);
        logic [3:0] ecx;
        ecx = ERRCNT ? ec : 4'd0;
        return {e, f, v, er, ft, dc, p, ecx};
    endfunction

    task automatic step(input bit rn, input logic [1:0] ab, input bit cl, input string nm,
                        input logic [17:0] e);
        exp_t x;
        reset   = rn;
        bus.a   = ab[1];
        bus.b   = ab[0];
        bus.clr = cl;
        x.chk   = 1'b1;
        x.name  = nm;
        x.exp   = e;
        sb.push_back(x);
        @(posedge c);
        #2;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge c);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.chk) begin
                    tests++;
                    if (act !== x.exp) begin
                        fails++;
                        $display("FAIL %s: got %h expected %h (e,f,v,err,fault,dc,pos,cnt)",
                                 x.name, act, x.exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset   = 1'b0;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.clr = 1'b0;

        // reset, sync, then steady 00
        step(0, 2'b00, 0, "rst0",  pk(0,0,0,0,0,0,8'd0,0));
        step(0, 2'b00, 0, "rst1",  pk(0,0,0,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "sync0", pk(0,0,0,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "hold0", pk(0,0,1,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "hold1", pk(0,0,1,0,0,0,8'd0,0));

        // four up steps
        step(1, 2'b01, 0, "up1",   pk(1,1,1,0,0,0,8'd1,0));
        step(1, 2'b10, 0, "up2",   pk(1,1,1,0,0,0,8'd2,0));
        step(1, 2'b11, 0, "up3",   pk(1,1,1,0,0,0,8'd3,0));
        step(1, 2'b00, 0, "up4",   pk(1,1,1,0,0,0,8'd4,0));
        step(1, 2'b00, 0, "hold4", pk(0,1,1,0,0,0,8'd4,0));

        // clr, then up/up/down/down with one direction change
        step(1, 2'b00, 1, "clr_a",   pk(0,0,0,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "sync_a",  pk(0,0,0,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "hold_a",  pk(0,0,1,0,0,0,8'd0,0));
        step(1, 2'b01, 0, "rev_up1", pk(1,1,1,0,0,0,8'd1,0));
        step(1, 2'b10, 0, "rev_up2", pk(1,1,1,0,0,0,8'd2,0));
        step(1, 2'b01, 0, "rev_dn1", pk(1,0,1,0,0,1,8'd1,0));
        step(1, 2'b00, 0, "rev_dn2", pk(1,0,1,0,0,0,8'd0,0));

        // reverse again, then illegal 01->11, fault, clr
        step(1, 2'b01, 0, "rev_up3",     pk(1,1,1,0,0,1,8'd1,0));
        step(1, 2'b11, 0, "illegal1",    pk(0,1,0,1,1,0,8'd1,1));
        step(1, 2'b11, 0, "fault_hold1", pk(0,1,0,0,1,0,8'd1,1));
        step(1, 2'b00, 0, "fault_hold2", pk(0,1,0,0,1,0,8'd1,1));
        step(1, 2'b00, 1, "clr_fault",   pk(0,0,0,0,0,0,8'd0,1));
        step(1, 2'b00, 0, "sync_b",      pk(0,0,0,0,0,0,8'd0,1));
        step(1, 2'b00, 0, "hold_b",      pk(0,0,1,0,0,0,8'd0,1));

        // 129 up steps: wraps through +127 -> -128 and ends at 0x81
        for (int unsigned k = 1; k <= 129; k++)
            step(1, k[1:0], 0, "up_run", pk(1,1,1,0,0,0,k[7:0],1));

        // illegal jump 01->11 with clr: clr wins, no err
        step(1, 2'b11, 1, "clr_illegal", pk(0,0,0,0,0,0,8'd0,1));
        step(1, 2'b11, 0, "sync_c",      pk(0,0,0,0,0,0,8'd0,1));
        step(1, 2'b11, 0, "hold_c",      pk(0,0,1,0,0,0,8'd0,1));

        // build err_cnt to 3, then reset while faulted
        step(1, 2'b01, 0, "illegal2",   pk(0,0,0,1,1,0,8'd0,2));
        step(1, 2'b01, 1, "clr_d",      pk(0,0,0,0,0,0,8'd0,2));
        step(1, 2'b01, 0, "sync_d",     pk(0,0,0,0,0,0,8'd0,2));
        step(1, 2'b01, 0, "hold_d",     pk(0,0,1,0,0,0,8'd0,2));
        step(1, 2'b11, 0, "illegal3",   pk(0,0,0,1,1,0,8'd0,3));
        step(1, 2'b11, 0, "fault_hold3",pk(0,0,0,0,1,0,8'd0,3));
        step(0, 2'b11, 0, "rst_fault",  pk(0,0,0,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "sync_e",     pk(0,0,0,0,0,0,8'd0,0));
        step(1, 2'b00, 0, "hold_e",     pk(0,0,1,0,0,0,8'd0,0));

        // first move down from 0 wraps to -1, no dir_chg
        step(1, 2'b11, 0, "down_wrap",  pk(1,0,1,0,0,0,8'hFF,0));
        step(1, 2'b11, 0, "hold_f",     pk(0,0,1,0,0,0,8'hFF,0));

        repeat (2) @(posedge c);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
